// File: rtl/muldiv_unit_if.sv
// Control/data bundle between decode/forwarding logic and the muldiv unit.
// The master side drives the controls and operands; the slave returns Busy/HI/LO.
interface muldiv_unit_if;
    logic        Start;
    logic [1:0]  MulDiv_Type;
    logic [1:0]  MulDiv_Write;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MulDiv_Type, MulDiv_Write, A, B,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MulDiv_Type, MulDiv_Write, A, B,
        output Busy, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO pair.
// The result is computed at launch and committed after a fixed Busy window.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_load;
    logic          w_done;
    logic          r_busy;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_tmp_hi;
    logic [31:0]   r_tmp_lo;
    logic          r_tmp_wr;

    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic          w_sa;
    logic          w_sb;
    logic [31:0]   w_abs_a;
    logic [31:0]   w_abs_b;
    logic [31:0]   w_den_s;
    logic [31:0]   w_den_u;
    logic [31:0]   w_q_mag;
    logic [31:0]   w_r_mag;
    logic [31:0]   w_quo_s;
    logic [31:0]   w_rem_s;
    logic [31:0]   w_quo_u;
    logic [31:0]   w_rem_u;
    logic [63:0]   w_res;
    logic          w_res_wr;

    // Low 64 bits of a sign-extended product equal the signed 32x32 result.
    assign w_prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    assign w_prod_u = {32'b0, md.A} * {32'b0, md.B};

    assign w_sa    = md.A[31];
    assign w_sb    = md.B[31];
    assign w_abs_a = w_sa ? (~md.A + 32'd1) : md.A;
    assign w_abs_b = w_sb ? (~md.B + 32'd1) : md.B;
    // Zero divisors are replaced so the dividers never see 0; result is discarded.
    assign w_den_s = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_den_u = (md.B == 32'd0) ? 32'd1 : md.B;
    assign w_q_mag = w_abs_a / w_den_s;
    assign w_r_mag = w_abs_a % w_den_s;
    assign w_quo_s = (w_sa ^ w_sb) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem_s = w_sa ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_quo_u = md.A / w_den_u;
    assign w_rem_u = md.A % w_den_u;

    always_comb begin
        w_res    = 64'd0;
        w_res_wr = 1'b1;
        unique case (md.MulDiv_Type)
            2'b00: w_res = w_prod_s;
            2'b01: w_res = w_prod_u;
            2'b10: w_res = {w_rem_s, w_quo_s};
            2'b11: w_res = {w_rem_u, w_quo_u};
            default: w_res = 64'd0;
        endcase
        if (md.MulDiv_Type[1] && (md.B == 32'd0))
            w_res_wr = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (md.Start) begin
                    w_state_nxt = S_BUSY;
                    w_load      = 1'b1;
                    w_cnt_nxt   = md.MulDiv_Type[1] ? CW'(DIV_CYCLES - 1)
                                                    : CW'(MULT_CYCLES - 1);
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= (w_state_nxt == S_BUSY);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_tmp_wr <= 1'b0;
        end else if (w_load) begin
            r_tmp_hi <= w_res[63:32];
            r_tmp_lo <= w_res[31:0];
            r_tmp_wr <= w_res_wr;
        end
    end

    // mthi/mtlo only land while idle and not launching an operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (r_tmp_wr) begin
                r_hi <= r_tmp_hi;
                r_lo <= r_tmp_lo;
            end
        end else if ((r_state == S_IDLE) && !md.Start) begin
            if (md.MulDiv_Write == 2'b01)
                r_hi <= md.A;
            else if (md.MulDiv_Write == 2'b10)
                r_lo <= md.A;
        end
    end

    assign md.Busy = r_busy;
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit that consumes the decoder's Start, MulDiv_Type and MulDiv_Write controls for mult, multu, div, divu, mthi and mtlo.
- Holds the architectural HI/LO registers. mfhi/mflo read them combinationally.
- Exposes Busy so the hazard unit stalls any muldiv-class instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse: launch operation selected by MulDiv_Type.
- MulDiv_Type  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled only when Start=1.
- MulDiv_Write  input  2  01 mthi, 10 mtlo, 00/11 no write.
- A  input  32  forwarded rs value (dividend / multiplicand / mthi-mtlo data).
- B  input  32  forwarded rt value (divisor / multiplier).
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, counter=0, Busy=0, HI=0, LO=0, pending result discarded. Takes effect immediately, including mid-operation.
- States: IDLE and BUSY.
- IDLE with Start=1 on an edge:
  - latch A, B and MulDiv_Type;
  - compute the 64-bit result into internal temp registers;
  - counter=N-1, where N=MULT_CYCLES or DIV_CYCLES;
  - go to BUSY and set Busy=1.
  - Start has priority over MulDiv_Write in the same cycle; the write is dropped.
- BUSY:
  - counter decrements each edge.
  - On the edge where counter==0: HI/LO <= temp, Busy=0, return to IDLE.
  - Busy is therefore high for exactly N cycles, starting the cycle after Start. New HI/LO are visible in the first cycle Busy=0.
- Start or MulDiv_Write while BUSY: ignored. The hazard unit guarantees neither occurs. The bench checks that HI/LO and the counter are unaffected.
- IDLE with MulDiv_Write=01: HI<=A on the edge. With 10: LO<=A. LO/HI untouched respectively. Zero latency; Busy stays 0.
- Results:
  - mult: signed 32x32 -> 64; HI=product[63:32], LO=product[31:0].
  - multu: same, unsigned.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (B=0, div or divu): the operation still runs the full DIV_CYCLES with Busy=1. HI/LO keep their prior values at completion.
- Signed overflow (div, A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0. No trap.
- Operands are latched at Start. Changes on A/B during BUSY have no effect.
- HI/LO outputs are the registers directly; no internal bypass of a same-cycle mthi/mtlo.

Test Plan:
- Reset, then Start with mult, A=0xFFFFFFFE (-2), B=3 -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 Busy cycles HI=0xFFFFFFFE, LO=0x00000001. A/B toggled during BUSY changes nothing.
- div, A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 -> HI/LO update on each edge, Busy never asserts. Then divu with B=0 -> 10 Busy cycles, HI/LO unchanged.
- div, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. mthi issued during BUSY -> ignored.
- Start mult, pull reset_n low at Busy cycle 3 -> Busy=0, HI=LO=0 immediately. After release, idle with no spurious completion.
